mmv_ram_slave: RTL and testbench
================================

Name: mmv_ram_slave

Overview:
- Synthesizable MemoryMapped responder: single-port on-chip RAM behind the MemoryMapped slave interface.
- Fixed, parameterised read latency and optional programmable busy gap after each accepted request.
- Serves as the counterpart to the master-side bench models.
- Also used as a scratch memory in real designs.

Parameters:
- DWIDTH, 8: data width.
- AWIDTH, 32: interface address width.
- MWIDTH, 8: memory address bits; depth = 2**MWIDTH words; legal range 1..AWIDTH.
- RDLAT, 2: read latency in clocks; legal range >=1.
- BUSY_GAP, 0: busy cycles inserted after each accepted request; legal range >=0.

Ports:
- reset  in  1  async reset, active-high
- clk  in  1  clock
- s_addr  in  AWIDTH  request address
- s_wreq  in  1  write request
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request
- s_rdat  out  DWIDTH  read data, qualified by s_rval
- s_rval  out  1  read response valid, one cycle per response
- s_busy  out  1  slave cannot accept; registered

Interface: reset reset, asynchronous, active-high; clock clk.

Behaviour:
- Acceptance
  - Request accepted at a rising edge when (s_wreq | s_rreq) & ~s_busy.
  - Requests presented while s_busy=1 are ignored; the master holds them.
- Addressing
  - Word index = s_addr[MWIDTH-1:0]; upper bits ignored, so aliasing is allowed.
- Simultaneous requests
  - If s_wreq and s_rreq are both high, the request is a write only; no read response is generated.
- Write
  - Accepted at edge N: mem[idx] <= s_wdat at edge N.
  - A read accepted at edge N+1 or later returns the new value.
- Read
  - Accepted at edge N: s_rval=1 and s_rdat=mem[idx] in the cycle after edge N+RDLAT-1, sampled by the master at edge N+RDLAT.
  - Data is the memory content at edge N.
  - Implemented as a RDLAT-deep valid/data shift pipeline, with the RAM read in stage 1.
- Ordering and throughput
  - Responses return in request order.
  - Back-to-back reads give back-to-back s_rval, one per clock.
  - s_rdat is don't-care while s_rval=0; hold the last value.
- Busy generation
  - Counter gap_cnt, width clog2(BUSY_GAP+1), minimum 1 bit.
  - BUSY_GAP=0: s_busy=0 every cycle after reset release.
  - BUSY_GAP=G>0: a request accepted at edge N loads gap_cnt=G and sets s_busy=1 after edge N.
  - gap_cnt decrements each edge; s_busy clears after edge N+G, so the next acceptance is possible at edge N+G+1.
- Reset (asynchronous, mid-operation)
  - s_busy=1, s_rval=0, s_rdat=0, pipeline valid bits cleared, gap_cnt=0.
  - In-flight reads are dropped; no s_rval for them after release.
  - s_busy deasserts after the first clk edge following reset release.
  - Memory contents are not cleared by reset; initial content is all-zero through initialisation.
- No error signalling: every accepted read receives exactly one response.

Test Plan:
- Fill and read back (RDLAT=2, BUSY_GAP=0):
  - Write 0xA5 to addr 0x03, then read 0x03 on the next cycle.
  - s_rval high exactly 2 edges after read acceptance; s_rdat=0xA5.
- Latency and streaming (RDLAT=3):
  - 4 back-to-back reads of addrs 0..3 holding 0x10..0x13.
  - s_rval high 4 consecutive cycles starting 3 edges after the first acceptance; data 0x10,0x11,0x12,0x13 in order.
- Busy gap (BUSY_GAP=2):
  - Continuous write requests.
  - Acceptances occur every 3rd edge; s_busy pattern after the first acceptance is 1,1,0 repeating.
  - Ignored requests are not written; verify by readback.
- Alias and simultaneous request (MWIDTH=8):
  - Write 0x5C to addr 0x0000_0107, read addr 0x07 -> 0x5C.
  - Assert s_wreq=s_rreq=1 to addr 0x07 with s_wdat=0x99 -> no s_rval; subsequent read returns 0x99.
- Reset mid-read (RDLAT=4):
  - Issue 2 reads, assert reset 2 edges later, release.
  - No s_rval ever appears for those reads; s_busy=1 during reset and until the first post-release edge.
  - Memory retains the 0x99 written earlier.
- RDLAT=1 corner: read accepted at edge N -> s_rval sampled at edge N+1.
- Read-after-write on consecutive edges returns the newly written value.

Source files
------------

// File: rtl/mmv_ram_slave.sv
// Single-port RAM responder on the MemoryMapped slave interface: fixed RDLAT read pipeline,
// optional BUSY_GAP busy window after every accepted request; memory contents survive reset.
module mmv_ram_slave #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 32,
  parameter int MWIDTH   = 8,
  parameter int RDLAT    = 2,
  parameter int BUSY_GAP = 0
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy
);

  localparam int GW    = (BUSY_GAP > 0) ? $clog2(BUSY_GAP + 1) : 1;
  localparam int DEPTH = 1 << MWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [MWIDTH-1:0] idx;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic [GW-1:0]     gap_cnt;
  logic [RDLAT:1]    vld;
  logic [DWIDTH-1:0] dat [1:RDLAT];

  // Upper address bits are deliberately ignored, so addresses alias modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^s_addr;

  assign idx    = s_addr[MWIDTH-1:0];
  assign acc    = (s_wreq | s_rreq) & ~s_busy;
  assign wr_acc = s_wreq & ~s_busy;
  // A simultaneous write+read request is treated as a write only.
  assign rd_acc = s_rreq & ~s_wreq & ~s_busy;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= s_wdat;
  end

  // Stage 1 samples the RAM; later stages only move data alongside a valid,
  // so the output data register holds its last response while s_rval is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int k = 1; k <= RDLAT; k++) dat[k] <= '0;
    end else begin
      vld[1] <= rd_acc;
      if (rd_acc) dat[1] <= mem[idx];
      for (int k = 2; k <= RDLAT; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign s_rval = vld[RDLAT];
  assign s_rdat = dat[RDLAT];

  // Busy comes up in reset and drops on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_busy  <= 1'b1;
      gap_cnt <= '0;
    end else if (acc && (BUSY_GAP > 0)) begin
      s_busy  <= 1'b1;
      gap_cnt <= GW'(BUSY_GAP);
    end else if (gap_cnt > GW'(1)) begin
      s_busy  <= 1'b1;
      gap_cnt <= gap_cnt - GW'(1);
    end else begin
      s_busy  <= 1'b0;
      gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mmv_ram_slave.sv
// Directed bench for mmv_ram_slave: five instances cover RDLAT 1..4, a busy gap of 2,
// aliasing, write+read collision and reset in the middle of outstanding reads.
module tb_mmv_ram_slave;

  logic        clk;
  logic        rst   [5];
  logic [31:0] addr  [5];
  logic        wreq  [5];
  logic [7:0]  wdat  [5];
  logic        rreq  [5];
  logic [7:0]  rdat  [5];
  logic        rval  [5];
  logic        busy  [5];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: RDLAT=2, 1: RDLAT=3, 2: RDLAT=2 with BUSY_GAP=2, 3: RDLAT=4, 4: RDLAT=1
  mmv_ram_slave #(.RDLAT(2), .BUSY_GAP(0)) u_a (
    .reset(rst[0]), .clk(clk), .s_addr(addr[0]), .s_wreq(wreq[0]), .s_wdat(wdat[0]),
    .s_rreq(rreq[0]), .s_rdat(rdat[0]), .s_rval(rval[0]), .s_busy(busy[0]));
  mmv_ram_slave #(.RDLAT(3), .BUSY_GAP(0)) u_b (
    .reset(rst[1]), .clk(clk), .s_addr(addr[1]), .s_wreq(wreq[1]), .s_wdat(wdat[1]),
    .s_rreq(rreq[1]), .s_rdat(rdat[1]), .s_rval(rval[1]), .s_busy(busy[1]));
  mmv_ram_slave #(.RDLAT(2), .BUSY_GAP(2)) u_c (
    .reset(rst[2]), .clk(clk), .s_addr(addr[2]), .s_wreq(wreq[2]), .s_wdat(wdat[2]),
    .s_rreq(rreq[2]), .s_rdat(rdat[2]), .s_rval(rval[2]), .s_busy(busy[2]));
  mmv_ram_slave #(.RDLAT(4), .BUSY_GAP(0)) u_d (
    .reset(rst[3]), .clk(clk), .s_addr(addr[3]), .s_wreq(wreq[3]), .s_wdat(wdat[3]),
    .s_rreq(rreq[3]), .s_rdat(rdat[3]), .s_rval(rval[3]), .s_busy(busy[3]));
  mmv_ram_slave #(.RDLAT(1), .BUSY_GAP(0)) u_e (
    .reset(rst[4]), .clk(clk), .s_addr(addr[4]), .s_wreq(wreq[4]), .s_wdat(wdat[4]),
    .s_rreq(rreq[4]), .s_rdat(rdat[4]), .s_rval(rval[4]), .s_busy(busy[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 20) begin
      tick();
      n++;
    end
    if (busy[i]) check($sformatf("idle_timeout_%0d", i), 32'd1, 32'd0);
  endtask

  // One request, accepted on the next edge; returns #1 after that edge.
  task automatic op(input int i, input bit w, input bit r, input logic [31:0] a,
                    input logic [7:0] d);
    wait_idle(i);
    addr[i] = a;
    wdat[i] = d;
    wreq[i] = w;
    rreq[i] = r;
    tick();
    wreq[i] = 1'b0;
    rreq[i] = 1'b0;
  endtask

  task automatic rd_check(input int i, input logic [31:0] a, input int lat,
                          input logic [7:0] exp, input string tag);
    op(i, 1'b0, 1'b1, a, 8'h00);
    for (int k = 1; k < lat; k++) begin
      check({tag, "_early"}, {31'd0, rval[i]}, 32'd0);
      tick();
    end
    check({tag, "_rval"}, {31'd0, rval[i]}, 32'd1);
    check({tag, "_rdat"}, {24'd0, rdat[i]}, {24'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      rst[i] = 1'b1; addr[i] = '0; wreq[i] = 1'b0; wdat[i] = '0; rreq[i] = 1'b0;
    end
    tick();
    tick();
    check("rst_busy", {31'd0, busy[0]}, 32'd1);
    check("rst_rval", {31'd0, rval[0]}, 32'd0);
    check("rst_rdat", {24'd0, rdat[0]}, 32'd0);
    for (int i = 0; i < 5; i++) rst[i] = 1'b0;
    #1;
    check("rel_busy_held", {31'd0, busy[0]}, 32'd1);
    tick();
    check("rel_busy_clear", {31'd0, busy[0]}, 32'd0);
    check("rel_busy_clear_c", {31'd0, busy[2]}, 32'd0);

    // Fill and read back on the very next cycle.
    op(0, 1'b1, 1'b0, 32'h03, 8'hA5);
    rd_check(0, 32'h03, 2, 8'hA5, "raw");
    tick();
    check("raw_single_pulse", {31'd0, rval[0]}, 32'd0);

    // Alias: 0x107 maps to word 0x07.
    op(0, 1'b1, 1'b0, 32'h0000_0107, 8'h5C);
    rd_check(0, 32'h07, 2, 8'h5C, "alias");
    // Write+read together acts as a write with no response.
    op(0, 1'b1, 1'b1, 32'h07, 8'h99);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("both_norval%0d", k), {31'd0, rval[0]}, 32'd0);
      tick();
    end
    rd_check(0, 32'h07, 2, 8'h99, "both_after");

    // Streaming, RDLAT=3.
    for (int k = 0; k < 4; k++) op(1, 1'b1, 1'b0, k, 8'h10 + 8'(k));
    for (int t = 0; t < 8; t++) begin
      if (t < 4) begin
        rreq[1] = 1'b1;
        addr[1] = t;
      end else begin
        rreq[1] = 1'b0;
      end
      tick();
      check($sformatf("strm_rval%0d", t), {31'd0, rval[1]}, {31'd0, (t >= 2 && t <= 5)});
      if (t >= 2 && t <= 5)
        check($sformatf("strm_rdat%0d", t), {24'd0, rdat[1]}, 32'h10 + (t - 2));
    end

    // Busy gap of 2 under continuous writes.
    for (int k = 0; k < 9; k++) op(2, 1'b1, 1'b0, k, 8'hEE);
    wait_idle(2);
    for (int k = 0; k < 9; k++) begin
      wreq[2] = 1'b1;
      addr[2] = k;
      wdat[2] = 8'h40 + 8'(k);
      tick();
      check($sformatf("gap_busy%0d", k), {31'd0, busy[2]}, {31'd0, (k % 3 != 2)});
    end
    wreq[2] = 1'b0;
    for (int k = 0; k < 9; k++)
      rd_check(2, k, 2, (k % 3 == 0) ? (8'h40 + 8'(k)) : 8'hEE, $sformatf("gap_rd%0d", k));

    // Reset with two reads in flight, RDLAT=4.
    op(3, 1'b1, 1'b0, 32'h07, 8'h99);
    op(3, 1'b0, 1'b1, 32'h07, 8'h00);
    op(3, 1'b0, 1'b1, 32'h01, 8'h00);
    tick();
    rst[3] = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy[3]}, 32'd1);
    check("mid_rst_rval", {31'd0, rval[3]}, 32'd0);
    check("mid_rst_rdat", {24'd0, rdat[3]}, 32'd0);
    tick();
    tick();
    check("mid_rst_busy2", {31'd0, busy[3]}, 32'd1);
    rst[3] = 1'b0;
    #1;
    check("mid_rel_busy", {31'd0, busy[3]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("mid_norval%0d", k), {31'd0, rval[3]}, 32'd0);
    end
    check("mid_busy_clear", {31'd0, busy[3]}, 32'd0);
    rd_check(3, 32'h07, 4, 8'h99, "mid_retain");

    // RDLAT=1 corner.
    op(4, 1'b1, 1'b0, 32'h20, 8'h3C);
    rd_check(4, 32'h20, 1, 8'h3C, "lat1");
    tick();
    check("lat1_single_pulse", {31'd0, rval[4]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
